// File: rtl/aes_pkg.sv
// Shared AES control definitions: sequencer state encoding and round counts.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    INIT     = 3'd2,
    ROUND    = 3'd3,
    FINAL    = 3'd4,
    DONE     = 3'd5
  } aes_state_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

endpackage

// File: rtl/aes_round_down_counter.sv
// Round-key index down-counter. Loads a start value, decrements on enable and
// parks at one, so it can never wrap below the last middle round.
module aes_round_down_counter #(
  parameter int CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [CNT_SIZE-1:0] load_val,
  input  logic                en,
  output logic [CNT_SIZE-1:0] o_count,
  output logic                o_is_one
);

  logic [CNT_SIZE-1:0] count;

  // Clear dominates load, load dominates decrement; decrement stops at one.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count > CNT_SIZE'(1))) begin
      count <= count - CNT_SIZE'(1);
    end
  end

  assign o_count  = count;
  assign o_is_one = (count == CNT_SIZE'(1));

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Round sequencer for the AES inverse cipher: walks round keys MAX_CNT..0,
// flags the AddRoundKey-only first round and the InvMixColumns-free last round,
// and handshakes start/done with the block controller.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | waiting for i_start, count held at 0
//  WAIT_KEY | start accepted, waiting for expanded keys
//  INIT     | load ciphertext, AddRoundKey with key MAX_CNT
//  ROUND    | middle round, key index = count (MAX_CNT-1 down to 1)
//  FINAL    | last round with key 0, InvMixColumns skipped
//  DONE     | one-cycle done pulse, then back to IDLE
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int MAX_CNT  = AES_NR_128,
  parameter int CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_key_ready,
  input  logic                i_cnt_en,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_data_load,
  output logic                o_first_round,
  output logic                o_last_round,
  output logic [CNT_SIZE-1:0] o_round_key_idx,
  output logic                o_done
);

  aes_state_t          state;
  aes_state_t          state_next;
  logic                cnt_clr;
  logic                cnt_load;
  logic                cnt_dec;
  logic [CNT_SIZE-1:0] count;
  logic                cnt_is_one;

  aes_round_down_counter #(
    .CNT_SIZE(CNT_SIZE)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (CNT_SIZE'(MAX_CNT - 1)),
    .en       (cnt_dec),
    .o_count  (count),
    .o_is_one (cnt_is_one)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter control; abort beats advance in every busy state.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (i_abort && (state != IDLE)) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) state_next = i_key_ready ? INIT : WAIT_KEY;
        end
        WAIT_KEY: begin
          if (i_key_ready) state_next = INIT;
        end
        INIT: begin
          if (i_cnt_en) begin
            state_next = ROUND;
            cnt_load   = 1'b1;
          end
        end
        ROUND: begin
          if (i_cnt_en) begin
            if (cnt_is_one) state_next = FINAL;
            else            cnt_dec    = 1'b1;
          end
        end
        FINAL: begin
          if (i_cnt_en) state_next = DONE;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    cnt_clr = (state_next == IDLE);
  end

  // Moore output decode from registered state and count only.
  always_comb begin
    o_busy          = (state != IDLE);
    o_data_load     = 1'b0;
    o_first_round   = 1'b0;
    o_last_round    = 1'b0;
    o_round_key_idx = '0;
    o_done          = 1'b0;
    case (state)
      INIT: begin
        o_data_load     = 1'b1;
        o_first_round   = 1'b1;
        o_round_key_idx = CNT_SIZE'(MAX_CNT);
      end
      ROUND:   o_round_key_idx = count;
      FINAL:   o_last_round    = 1'b1;
      DONE:    o_done          = 1'b1;
      default: ;
    endcase
  end

endmodule
